// File: rtl/dvp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dvp_pkg
//  Purpose  : Shared DVP definitions: transmitter/receiver state encodings,
//             default video timing and a counter-width helper.
//  Revision : 1.0
// ============================================================================
package dvp_pkg;

    localparam int c_DVP_DATA_W = 8;
    localparam int c_RGB_PXL_W  = 16;
    localparam int c_PCLK_HALF  = 2;
    localparam int c_H_ACTIVE   = 640;
    localparam int c_H_BLANK    = 144;
    localparam int c_H_SYNC     = 16;
    localparam int c_V_ACTIVE   = 480;
    localparam int c_V_SYNC     = 3;
    localparam int c_V_BP       = 17;
    localparam int c_V_FP       = 10;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_VSYNC  = 3'd1,
        TX_VBP    = 3'd2,
        TX_ACTIVE = 3'd3,
        TX_VFP    = 3'd4
    } dvp_tx_state_t;

    typedef enum logic [1:0] {
        RX_WAIT_VSYNC = 2'd0,
        RX_WAIT_HREF  = 2'd1,
        RX_CAP_HI     = 2'd2,
        RX_CAP_LO     = 2'd3
    } dvp_rx_state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int dvp_cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dvp_pclk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : dvp_pclk_gen
//  Purpose  : Free-running pixel clock divider with a fall-cycle strobe.
//  Revision : 1.0
// ============================================================================
module dvp_pclk_gen
    import dvp_pkg::*;
#(
    parameter int PCLK_HALF = c_PCLK_HALF
) (
    input  logic clk,
    input  logic rst,
    output logic pclk_o,
    output logic fall_o
);

    logic r_pclk;
    logic w_toggle;

    generate
        if (PCLK_HALF <= 1) begin : g_div1
            assign w_toggle = 1'b1;
        end else begin : g_divn
            localparam int                 c_DIV_W    = dvp_cnt_w(PCLK_HALF);
            localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(PCLK_HALF - 1);

            logic [c_DIV_W-1:0] r_div;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_div <= '0;
                end else if (r_div == c_DIV_LAST) begin
                    r_div <= '0;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end

            assign w_toggle = (r_div == c_DIV_LAST);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pclk <= 1'b0;
        end else if (w_toggle) begin
            r_pclk <= ~r_pclk;
        end
    end

    assign pclk_o = r_pclk;
    // Closing edge of this cycle takes pclk from 1 to 0.
    assign fall_o = r_pclk & w_toggle;

endmodule
`default_nettype wire

// File: rtl/dvp_tx_frame_gen.sv
`default_nettype none
// ============================================================================
//  Module   : dvp_tx_frame_gen
//  Purpose  : DVP transmitter: frame timing FSM, RGB565 byte serialiser,
//             sync generation and underrun tracking.
//  Revision : 1.0
// ============================================================================
module dvp_tx_frame_gen
    import dvp_pkg::*;
#(
    parameter int DVP_DATA_W = c_DVP_DATA_W,
    parameter int RGB_PXL_W  = c_RGB_PXL_W,
    parameter int PCLK_HALF  = c_PCLK_HALF,
    parameter int H_ACTIVE   = c_H_ACTIVE,
    parameter int H_BLANK    = c_H_BLANK,
    parameter int H_SYNC     = c_H_SYNC,
    parameter int V_ACTIVE   = c_V_ACTIVE,
    parameter int V_SYNC     = c_V_SYNC,
    parameter int V_BP       = c_V_BP,
    parameter int V_FP       = c_V_FP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic [RGB_PXL_W-1:0]  pxl_i,
    input  logic                  pxl_vld_i,
    output logic                  pxl_rdy_o,
    input  logic                  underrun_clr_i,
    output logic                  dvp_pclk_o,
    output logic [DVP_DATA_W-1:0] dvp_d_o,
    output logic                  dvp_href_o,
    output logic                  dvp_vsync_o,
    output logic                  dvp_hsync_o,
    output logic                  frame_done_o,
    output logic                  underrun_o
);

    localparam int c_LINE_SLOTS  = 2 * H_ACTIVE + H_BLANK;
    localparam int c_FRAME_LINES = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int c_SLOT_W      = dvp_cnt_w(c_LINE_SLOTS + 1);
    localparam int c_LINE_W      = dvp_cnt_w(c_FRAME_LINES);

    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST  = c_SLOT_W'(c_LINE_SLOTS - 1);
    localparam logic [c_SLOT_W-1:0] c_HREF_END   = c_SLOT_W'(2 * H_ACTIVE);
    localparam logic [c_SLOT_W-1:0] c_HSYNC_END  = c_SLOT_W'(2 * H_ACTIVE + H_SYNC);
    localparam logic [c_LINE_W-1:0] c_VSYNC_LAST = c_LINE_W'(V_SYNC - 1);
    localparam logic [c_LINE_W-1:0] c_VBP_LAST   = c_LINE_W'(V_SYNC + V_BP - 1);
    localparam logic [c_LINE_W-1:0] c_ACT_LAST   = c_LINE_W'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [c_LINE_W-1:0] c_FRAME_LAST = c_LINE_W'(c_FRAME_LINES - 1);

    logic                  w_fall;
    dvp_tx_state_t         r_state;
    dvp_tx_state_t         w_state_nxt;
    logic [c_SLOT_W-1:0]   r_slot;
    logic [c_SLOT_W-1:0]   w_slot_nxt;
    logic [c_LINE_W-1:0]   r_line;
    logic [c_LINE_W-1:0]   w_line_nxt;
    logic                  w_frame_end;
    logic                  w_href_nxt;
    logic                  w_hsync_nxt;
    logic                  w_vsync_nxt;
    logic                  w_hi_nxt;
    logic [DVP_DATA_W-1:0] r_d;
    logic [DVP_DATA_W-1:0] r_lo;
    logic                  r_href;
    logic                  r_vsync;
    logic                  r_hsync;
    logic                  r_underrun;

    dvp_pclk_gen #(
        .PCLK_HALF (PCLK_HALF)
    ) u_pclk_gen (
        .clk    (clk),
        .rst    (rst),
        .pclk_o (dvp_pclk_o),
        .fall_o (w_fall)
    );

    // Counters describe the slot currently on the bus; the line counter spans
    // the whole frame so state changes fall on fixed line indices.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= TX_IDLE;
            r_slot  <= '0;
            r_line  <= '0;
        end else if (w_fall) begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
            r_line  <= w_line_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_line_nxt  = r_line;
        w_frame_end = 1'b0;

        if (r_state == TX_IDLE) begin
            if (enable_i) begin
                w_state_nxt = TX_VSYNC;
            end
        end else if (r_slot != c_SLOT_LAST) begin
            w_slot_nxt = r_slot + 1'b1;
        end else begin
            w_slot_nxt = '0;
            w_line_nxt = r_line + 1'b1;
            case (r_state)
                TX_VSYNC:  if (r_line == c_VSYNC_LAST) w_state_nxt = TX_VBP;
                TX_VBP:    if (r_line == c_VBP_LAST)   w_state_nxt = TX_ACTIVE;
                TX_ACTIVE: if (r_line == c_ACT_LAST)   w_state_nxt = TX_VFP;
                TX_VFP: begin
                    if (r_line == c_FRAME_LAST) begin
                        w_line_nxt  = '0;
                        w_frame_end = 1'b1;
                        w_state_nxt = enable_i ? TX_VSYNC : TX_IDLE;
                    end
                end
                default:   w_state_nxt = TX_IDLE;
            endcase
        end

        w_href_nxt  = (w_state_nxt == TX_ACTIVE) && (w_slot_nxt < c_HREF_END);
        w_vsync_nxt = (w_state_nxt == TX_VSYNC);
        w_hsync_nxt = ((w_state_nxt == TX_VBP) || (w_state_nxt == TX_ACTIVE) ||
                       (w_state_nxt == TX_VFP)) &&
                      (w_slot_nxt >= c_HREF_END) && (w_slot_nxt < c_HSYNC_END);
        // Active region starts at slot 0, so even slots carry the high byte.
        w_hi_nxt    = w_href_nxt && !w_slot_nxt[0];
    end

    assign pxl_rdy_o    = w_fall & w_hi_nxt;
    assign frame_done_o = w_fall & w_frame_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d        <= '0;
            r_lo       <= '0;
            r_href     <= 1'b0;
            r_vsync    <= 1'b0;
            r_hsync    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_fall) begin
                r_href  <= w_href_nxt;
                r_vsync <= w_vsync_nxt;
                r_hsync <= w_hsync_nxt;
                if (w_hi_nxt) begin
                    if (pxl_vld_i) begin
                        r_d  <= pxl_i[RGB_PXL_W-1 -: DVP_DATA_W];
                        r_lo <= pxl_i[DVP_DATA_W-1:0];
                    end else begin
                        r_d  <= '0;
                        r_lo <= '0;
                    end
                end else if (w_href_nxt) begin
                    r_d <= r_lo;
                end else begin
                    r_d <= '0;
                end
            end
            if (pxl_rdy_o && !pxl_vld_i) begin
                r_underrun <= 1'b1;
            end else if (underrun_clr_i) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign dvp_d_o     = r_d;
    assign dvp_href_o  = r_href;
    assign dvp_vsync_o = r_vsync;
    assign dvp_hsync_o = r_hsync;
    assign underrun_o  = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_dvp_tx_frame_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dvp_tx_frame_gen
//  Purpose  : Randomised self-checking bench for dvp_tx_frame_gen against a
//             slot-indexed frame model.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_dvp_tx_frame_gen;

    localparam int PH  = 2;
    localparam int HA  = 4;
    localparam int HB  = 4;
    localparam int HS  = 2;
    localparam int VA  = 2;
    localparam int VS  = 1;
    localparam int VBP = 1;
    localparam int VFP = 1;
    localparam int LS  = 2 * HA + HB;
    localparam int NL  = VS + VBP + VA + VFP;
    localparam int FS  = LS * NL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable_i = 1'b0;
    logic [15:0] pxl_i = '0;
    logic        pxl_vld_i = 1'b0;
    logic        underrun_clr_i = 1'b0;
    logic        pxl_rdy_o;
    logic        dvp_pclk_o;
    logic [7:0]  dvp_d_o;
    logic        dvp_href_o;
    logic        dvp_vsync_o;
    logic        dvp_hsync_o;
    logic        frame_done_o;
    logic        underrun_o;

    dvp_tx_frame_gen #(
        .DVP_DATA_W (8),
        .RGB_PXL_W  (16),
        .PCLK_HALF  (PH),
        .H_ACTIVE   (HA),
        .H_BLANK    (HB),
        .H_SYNC     (HS),
        .V_ACTIVE   (VA),
        .V_SYNC     (VS),
        .V_BP       (VBP),
        .V_FP       (VFP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable_i       (enable_i),
        .pxl_i          (pxl_i),
        .pxl_vld_i      (pxl_vld_i),
        .pxl_rdy_o      (pxl_rdy_o),
        .underrun_clr_i (underrun_clr_i),
        .dvp_pclk_o     (dvp_pclk_o),
        .dvp_d_o        (dvp_d_o),
        .dvp_href_o     (dvp_href_o),
        .dvp_vsync_o    (dvp_vsync_o),
        .dvp_hsync_o    (dvp_hsync_o),
        .frame_done_o   (frame_done_o),
        .underrun_o     (underrun_o)
    );

    always #5 clk = ~clk;

    // Model: clock cycles since reset release, frame slot position, bus byte.
    int         m_cyc;
    bit         m_run;
    int         m_p;
    logic [7:0] m_d;
    logic [7:0] m_lo;
    bit         m_ur;
    int         m_k;

    bit cfg_en;
    bit cfg_seq;
    int cfg_vld_pct;
    int cfg_clr_pct;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, m_cyc, got, exp);
        end
    endtask

    function automatic bit href_at(input int p);
        int line, s;
        line = p / LS;
        s    = p % LS;
        return (line >= VS + VBP) && (line < VS + VBP + VA) && (s < 2 * HA);
    endfunction

    function automatic bit vsync_at(input int p);
        return (p / LS) < VS;
    endfunction

    function automatic bit hsync_at(input int p);
        int s;
        s = p % LS;
        return ((p / LS) >= VS) && (s >= 2 * HA) && (s < 2 * HA + HS);
    endfunction

    task automatic model_reset();
        m_cyc = 0;
        m_run = 1'b0;
        m_p   = 0;
        m_d   = '0;
        m_lo  = '0;
        m_ur  = 1'b0;
    endtask

    // Called at a falling clk edge: drive inputs, check, advance the model.
    task automatic tick_body();
        bit         fall, nrun, done_e, rdy_e, vld;
        int         np;
        logic [15:0] px;

        vld = ($urandom_range(99) < cfg_vld_pct);
        px  = cfg_seq ? (16'h1234 + 16'(m_k) * 16'h4444) : 16'($urandom);
        enable_i       = cfg_en;
        pxl_vld_i      = vld;
        pxl_i          = px;
        underrun_clr_i = ($urandom_range(99) < cfg_clr_pct);
        #1;

        fall = (m_cyc % (2 * PH)) == (2 * PH - 1);
        nrun = m_run;
        np   = m_p;
        if (fall) begin
            if (!m_run) begin
                if (cfg_en) begin
                    nrun = 1'b1;
                    np   = 0;
                end
            end else if (m_p == FS - 1) begin
                if (cfg_en) np = 0;
                else        nrun = 1'b0;
            end else begin
                np = m_p + 1;
            end
        end
        done_e = fall && m_run && (m_p == FS - 1);
        rdy_e  = fall && nrun && href_at(np) && ((np % LS) % 2 == 0);

        chk("pclk",       32'(dvp_pclk_o),   32'((m_cyc / PH) % 2));
        chk("href",       32'(dvp_href_o),   32'(m_run && href_at(m_p)));
        chk("vsync",      32'(dvp_vsync_o),  32'(m_run && vsync_at(m_p)));
        chk("hsync",      32'(dvp_hsync_o),  32'(m_run && hsync_at(m_p)));
        chk("data",       32'(dvp_d_o),      32'(m_d));
        chk("underrun",   32'(underrun_o),   32'(m_ur));
        chk("pxl_rdy",    32'(pxl_rdy_o),    32'(rdy_e));
        chk("frame_done", 32'(frame_done_o), 32'(done_e));

        if (fall) begin
            if (nrun && href_at(np)) begin
                if ((np % LS) % 2 == 0) begin
                    if (vld) begin
                        m_d  = px[15:8];
                        m_lo = px[7:0];
                        m_k++;
                    end else begin
                        m_d  = '0;
                        m_lo = '0;
                    end
                end else begin
                    m_d = m_lo;
                end
            end else begin
                m_d = '0;
            end
            m_run = nrun;
            m_p   = np;
        end
        if (rdy_e && !vld)        m_ur = 1'b1;
        else if (underrun_clr_i)  m_ur = 1'b0;
        m_cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            tick_body();
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pclk"},  32'(dvp_pclk_o),   32'd0);
        chk({tag, "_data"},  32'(dvp_d_o),      32'd0);
        chk({tag, "_href"},  32'(dvp_href_o),   32'd0);
        chk({tag, "_vsync"}, 32'(dvp_vsync_o),  32'd0);
        chk({tag, "_hsync"}, 32'(dvp_hsync_o),  32'd0);
        chk({tag, "_rdy"},   32'(pxl_rdy_o),    32'd0);
        chk({tag, "_done"},  32'(frame_done_o), 32'd0);
        chk({tag, "_ur"},    32'(underrun_o),   32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        tick_body();
    endtask

    initial begin
        m_k = 0;
        model_reset();
        cfg_en = 1'b0; cfg_seq = 1'b1; cfg_vld_pct = 100; cfg_clr_pct = 0;

        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        release_reset();
        run(10);

        // Sequential pixels, always valid, continuous frames.
        cfg_en = 1'b1;
        run(250);

        // Random pixels, occasional stalls and clears.
        cfg_seq = 1'b0; cfg_vld_pct = 70; cfg_clr_pct = 15;
        run(580);

        // Enable dropped inside the first active line: frame must finish.
        cfg_en = 1'b0;
        run(300);

        // Restart, then reset pulse in the middle of the active region.
        cfg_en = 1'b1; cfg_seq = 1'b1; cfg_vld_pct = 100; cfg_clr_pct = 0;
        run(130);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        repeat (3) @(negedge clk);
        release_reset();

        run(260);
        cfg_seq = 1'b0; cfg_vld_pct = 50; cfg_clr_pct = 30;
        run(300);
        cfg_en = 1'b0;
        run(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dvp_tx_frame_gen.md
DVP_TX_FRAME_GEN -- requirements
Module: dvp_tx_frame_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DVP_DATA_W, 8, DVP byte width; RGB_PXL_W, 16, input RGB565 pixel width; PCLK_HALF, 2, clk cycles per pclk half-period (>=1); H_ACTIVE, 640, pixels per line; H_BLANK, 144, blank pclk slots per line; H_SYNC, 16, hsync slots (<=H_BLANK); V_ACTIVE, 480, active lines; V_SYNC, 3, vsync lines; V_BP, 17, back-porch lines; V_FP, 10, front-porch lines.
REQ-002 Ports SHALL be: clk in 1 sole clock; rst in 1 reset, asynchronous, active-high; enable_i in 1 frame generation enable; pxl_i in RGB_PXL_W pixel; pxl_vld_i in 1 pixel valid; pxl_rdy_o out 1 pixel ready; underrun_clr_i in 1 clears underrun_o; dvp_pclk_o out 1 pixel clock; dvp_d_o out DVP_DATA_W data; dvp_href_o out 1; dvp_vsync_o out 1; dvp_hsync_o out 1; frame_done_o out 1 one-cycle pulse; underrun_o out 1 sticky flag.

Function
REQ-003 dvp_pclk_o SHALL free-run after reset, toggling every PCLK_HALF clk cycles, starting low; one pclk period = one slot.
REQ-004 "Fall cycle" = clk cycle whose closing edge drives pclk 1->0; dvp_d_o, href, vsync, hsync SHALL change only at that edge (stable at pclk rising edge).
REQ-005 FSM states SHALL be IDLE, VSYNC, VBP, ACTIVE, VFP; line = 2*H_ACTIVE+H_BLANK slots in every state except IDLE.
REQ-006 IDLE -> VSYNC at a fall cycle with enable_i=1; VSYNC (V_SYNC lines, vsync=1) -> VBP (V_BP lines) -> ACTIVE (V_ACTIVE lines) -> VFP (V_FP lines) -> VSYNC if enable_i=1 else IDLE.
REQ-007 In ACTIVE, href SHALL be 1 for the first 2*H_ACTIVE slots of each line, 0 for the remaining H_BLANK slots; href SHALL be 0 in all other states.
REQ-008 hsync SHALL be 1 for the first H_SYNC slots of each line's blank portion in VBP, ACTIVE and VFP; 0 otherwise.
REQ-009 Each pixel SHALL occupy two consecutive href slots: pxl[15:8] then pxl[7:0]; dvp_d_o SHALL be 0 when href=0.
REQ-010 pxl_rdy_o SHALL be 1 only in the fall cycle preceding a high-byte slot; the transfer occurs when pxl_rdy_o and pxl_vld_i are both 1 in that cycle; pxl_rdy_o SHALL NOT depend combinationally on pxl_vld_i.
REQ-011 Missing pixel (pxl_vld_i=0 at pxl_rdy_o) SHALL emit 0x00 for both bytes and set underrun_o; timing SHALL be unaffected.
REQ-012 underrun_o SHALL stay set until underrun_clr_i=1; clear and set in the same cycle -> set wins.
REQ-013 frame_done_o SHALL pulse for one clk cycle at the fall cycle ending the last VFP slot.
REQ-014 enable_i deassertion mid-frame SHALL NOT truncate the frame; it takes effect at REQ-006 decision point.
REQ-015 Slot, line and frame counters SHALL wrap to 0 at their terminal counts with no idle slot between lines or frames.

Reset
REQ-016 On rst=1, immediately and asynchronously: state IDLE; all counters 0; dvp_pclk_o, dvp_d_o, href, vsync, hsync, pxl_rdy_o, frame_done_o, underrun_o = 0.
REQ-017 Reset mid-frame SHALL abort the frame; after release, generation restarts at VSYNC only via REQ-006.

Structure
REQ-018 FSM state encoding and default timing constants SHALL reside in shared package dvp_pkg, alongside the receiver's definitions.
REQ-019 pclk divider and fall-cycle strobe SHALL be sub-module dvp_pclk_gen; all other logic in dvp_tx_frame_gen.

Verification (H_ACTIVE=4, H_BLANK=4, H_SYNC=2, V_ACTIVE=2, V_SYNC=1, V_BP=1, V_FP=1, PCLK_HALF=2)
REQ-020 Enable with 8 pixels 0x1234,0x5678,... always valid -> vsync 1 line (12 slots), 1 VBP line, 2 lines of 8 href slots with bytes 12,34,56,78...; frame_done_o after 60 slots.
REQ-021 pxl_vld_i=0 for 2nd pixel -> bytes 0x00,0x00 in slots 3-4, underrun_o=1, line length still 12 slots.
REQ-022 underrun_clr_i and new underrun same cycle -> underrun_o stays 1; clr alone -> 0 next cycle.
REQ-023 Drop enable_i during first ACTIVE line -> frame completes, frame_done_o pulses, then IDLE with all syncs 0.
REQ-024 rst pulse mid-ACTIVE -> all outputs 0 same cycle; re-enable -> fresh VSYNC, first pixel byte is high byte.
REQ-025 Every cycle: dvp_d_o/href/vsync/hsync stable across each pclk rising edge; pxl_rdy_o only at REQ-010 cycles.
